// File: rtl/fb_scanout_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// fb_scanout_arbiter_pkg
//   Shared VGA timing constants, the 12-bit colour type and the clear-engine
//   state encoding used by the framebuffer scanout arbiter.
//   No ports.
// ----------------------------------------------------------------------------
package fb_scanout_arbiter_pkg;

    // 640x480 @ 60 Hz horizontal timing, in pixel clocks
    localparam int HPIXELS = 640;
    localparam int HFP     = 16;
    localparam int HSPULSE = 96;
    localparam int HBP     = 48;
    localparam int WIDTH   = HPIXELS + HFP + HSPULSE + HBP;   // 800

    // Vertical timing, in lines
    localparam int VPIXELS = 480;
    localparam int VFP     = 10;
    localparam int VSPULSE = 2;
    localparam int VBP     = 33;
    localparam int HEIGHT  = VPIXELS + VFP + VSPULSE + VBP;   // 525

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } color12_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VB = 2'd1,
        CLEAR   = 2'd2
    } clr_state_t;

endpackage

// File: rtl/fb_scanout_arbiter_if.sv
// ----------------------------------------------------------------------------
// fb_scanout_arbiter_if
//   Bundles every non-clock signal of the scanout arbiter.
//   slave  : arbiter view (drives wr_ready, clear_busy, mem_*, pix_*, frame_start)
//   master : environment view (drives hc/vc, writer, clear request, mem_rdata)
//   hc_in/vc_in   vga counters            wr_*      writer valid/ready port
//   clear_*       clear engine control     mem_*     single RAM port
//   pix_*         colour to vga            frame_start  pulse at hc=0,vc=0
// ----------------------------------------------------------------------------
interface fb_scanout_arbiter_if #(
    parameter int ADDR_W = 15
);
    logic [9:0]        hc_in;
    logic [9:0]        vc_in;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [11:0]       wr_data;
    logic              wr_ready;
    logic              clear_req;
    logic [11:0]       clear_col;
    logic              clear_busy;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [11:0]       mem_wdata;
    logic [11:0]       mem_rdata;
    logic [3:0]        pix_red;
    logic [3:0]        pix_green;
    logic [3:0]        pix_blue;
    logic              frame_start;

    modport slave (
        input  hc_in, vc_in, wr_valid, wr_addr, wr_data, clear_req, clear_col, mem_rdata,
        output wr_ready, clear_busy, mem_en, mem_we, mem_addr, mem_wdata,
               pix_red, pix_green, pix_blue, frame_start
    );

    modport master (
        output hc_in, vc_in, wr_valid, wr_addr, wr_data, clear_req, clear_col, mem_rdata,
        input  wr_ready, clear_busy, mem_en, mem_we, mem_addr, mem_wdata,
               pix_red, pix_green, pix_blue, frame_start
    );
endinterface

// File: rtl/fb_scanout_arbiter_lookahead.sv
// ----------------------------------------------------------------------------
// fb_scanout_arbiter_lookahead
//   Combinational position two pixel clocks ahead of the vga counters, with
//   line and frame wrap, plus a flag for "inside the visible 640x480 area".
//   i_hc, i_vc   current vga counters
//   o_hla, o_vla lookahead counters
//   o_visible    lookahead position is visible
// ----------------------------------------------------------------------------
module fb_scanout_arbiter_lookahead
    import fb_scanout_arbiter_pkg::*;
(
    input  logic [9:0] i_hc,
    input  logic [9:0] i_vc,
    output logic [9:0] o_hla,
    output logic [9:0] o_vla,
    output logic       o_visible
);

    logic [10:0] w_hsum;

    always_comb begin
        w_hsum = {1'b0, i_hc} + 11'd2;
        o_hla  = w_hsum[9:0];
        o_vla  = i_vc;
        if (w_hsum >= 11'(WIDTH)) begin
            o_hla = 10'(w_hsum - 11'(WIDTH));
            o_vla = (i_vc == 10'(HEIGHT - 1)) ? '0 : i_vc + 10'd1;
        end
        o_visible = (o_hla < 10'(HPIXELS)) && (o_vla < 10'(VPIXELS));
    end

endmodule

// File: rtl/fb_scanout_arbiter.sv
// ----------------------------------------------------------------------------
// fb_scanout_arbiter
//   Owns the single port of the synchronous framebuffer RAM. Scanout reads,
//   issued two clocks ahead of the vga counters, always win; remaining free
//   cycles go to the clear engine (when clearing) or to the graphics writer.
//   A read strobe's data is captured into the pixel register one clock later,
//   so the colour for screen pixel (x,y) is presented while hc=x, vc=y.
//   vgaclk   pixel clock            rst  asynchronous, active-high reset
//   bus      fb_scanout_arbiter_if slave modport (writer, clear, RAM, pixel)
// ----------------------------------------------------------------------------
module fb_scanout_arbiter
    import fb_scanout_arbiter_pkg::*;
#(
    parameter int FB_W   = 160,
    parameter int FB_H   = 120,
    parameter int SCALE  = 4,
    parameter int ADDR_W = 15
) (
    input  logic                 vgaclk,
    input  logic                 rst,
    fb_scanout_arbiter_if.slave  bus
);

    localparam int FB_N = FB_W * FB_H;

    logic [9:0]        w_hla;
    logic [9:0]        w_vla;
    logic              w_visible;
    logic              w_scan;
    logic [ADDR_W-1:0] w_scan_addr;
    logic              w_clr_write;
    logic              w_latch_col;

    clr_state_t        r_state;
    clr_state_t        w_next;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_next;
    color12_t          r_clr_col;
    logic              r_busy;
    logic              r_slot_d;
    logic [11:0]       r_pix;

    fb_scanout_arbiter_lookahead u_lookahead (
        .i_hc      (bus.hc_in),
        .i_vc      (bus.vc_in),
        .o_hla     (w_hla),
        .o_vla     (w_vla),
        .o_visible (w_visible)
    );

    // One read per framebuffer pixel: only the first screen column of each
    // SCALE-wide group fetches.
    assign w_scan      = w_visible && ((int'(w_hla) % SCALE) == 0);
    assign w_scan_addr = ADDR_W'((int'(w_vla) / SCALE) * FB_W + int'(w_hla) / SCALE);

    // RAM port mux. Held idle while rst is high so every output reads 0
    // the moment reset is applied, not only after the next edge.
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.wr_ready  = 1'b0;
        w_clr_write   = 1'b0;
        if (rst) begin
            bus.mem_en = 1'b0;
        end else if (w_scan) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = w_scan_addr;
        end else if (r_state == CLEAR) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = 1'b1;
            bus.mem_addr  = r_ptr;
            bus.mem_wdata = r_clr_col;
            w_clr_write   = 1'b1;
        end else begin
            bus.wr_ready = 1'b1;
            if (bus.wr_valid) begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = bus.wr_addr;
                bus.mem_wdata = bus.wr_data;
            end
        end
    end

    // Clear engine next-state
    always_comb begin
        w_next      = r_state;
        w_ptr_next  = r_ptr;
        w_latch_col = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.clear_req) begin
                    w_next      = WAIT_VB;
                    w_latch_col = 1'b1;
                end
            end
            WAIT_VB: begin
                if (bus.vc_in >= 10'(VPIXELS)) begin
                    w_next     = CLEAR;
                    w_ptr_next = '0;
                end
            end
            CLEAR: begin
                if (w_clr_write) begin
                    if (r_ptr == ADDR_W'(FB_N - 1)) begin
                        w_next     = IDLE;
                        w_ptr_next = '0;
                    end else begin
                        w_ptr_next = r_ptr + 1'b1;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge vgaclk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_clr_col <= '0;
            r_busy    <= 1'b0;
            r_slot_d  <= 1'b0;
            r_pix     <= '0;
        end else begin
            r_state  <= w_next;
            r_ptr    <= w_ptr_next;
            // busy follows next state so it lines up with r_state
            r_busy   <= (w_next != IDLE);
            r_slot_d <= w_scan;
            if (w_latch_col) begin
                r_clr_col <= color12_t'(bus.clear_col);
            end
            if (r_slot_d) begin
                r_pix <= bus.mem_rdata;
            end
        end
    end

    assign bus.clear_busy  = r_busy;
    assign bus.pix_red     = r_pix[11:8];
    assign bus.pix_green   = r_pix[7:4];
    assign bus.pix_blue    = r_pix[3:0];
    assign bus.frame_start = !rst && (bus.hc_in == '0) && (bus.vc_in == '0);

endmodule

// File: tb/tb_fb_scanout_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fb_scanout_arbiter
//   Directed bench: drives the vga counters (with jumps to skip idle lines),
//   models the synchronous RAM, and checks scan reads, pixel output, writer
//   handshakes and the clear engine against values derived from the vga
//   counters.
// ----------------------------------------------------------------------------
module tb_fb_scanout_arbiter;

    localparam int ADDR_W = 15;
    localparam int FB_N   = 19200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fb_scanout_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    fb_scanout_arbiter #(
        .FB_W   (160),
        .FB_H   (120),
        .SCALE  (4),
        .ADDR_W (ADDR_W)
    ) dut (
        .vgaclk (clk),
        .rst    (rst),
        .bus    (bus)
    );

    // ---------------- RAM model: 1-cycle synchronous read ----------------
    logic [11:0] ram [0:(1<<ADDR_W)-1];
    logic [11:0] rd_q;
    logic        ram_load = 1'b1;

    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < (1<<ADDR_W); i++) ram[i] <= 12'(i);
            rd_q <= '0;
        end else if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            rd_q <= ram[bus.mem_addr];
        end
    end
    assign bus.mem_rdata = rd_q;

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- monitor state ----------------
    int  mode   = 0;     // 0: no writes expected, 1: writer phase, 2: clear phase
    bit  mon_on = 1'b0;
    int  epoch  = 0;
    logic [11:0] exp_col = '0;

    int scan_err = 0, spur_err = 0, ready_err = 0, pix_err = 0, pix_cnt = 0;
    int unexp_wr = 0, wr_cnt = 0, hs_cnt = 0, hs_err = 0, wr_bad = 0, clr_err = 0;
    int clr_next = 0, first_clr_vc = -1, first_clr_hc = -1;

    logic [11:0] snap_val [160];
    int          snap_row [160];
    int          snap_ep  [160];

    initial begin
        for (int i = 0; i < 160; i++) begin
            snap_val[i] = '0;
            snap_row[i] = -1;
            snap_ep[i]  = -1;
        end
    end

    always @(negedge clk) begin : mon
        int h2, v2, ea, col;
        bit slot, wr, hs, rdy_bad;
        h2 = int'(bus.hc_in) + 2;
        v2 = int'(bus.vc_in);
        if (h2 >= 800) begin
            h2 = h2 - 800;
            v2 = (v2 == 524) ? 0 : v2 + 1;
        end
        slot = (h2 < 640) && (v2 < 480) && (h2 % 4 == 0);
        ea   = (v2 / 4) * 160 + h2 / 4;
        wr   = bus.mem_en && bus.mem_we;
        hs   = bus.wr_valid && bus.wr_ready;
        rdy_bad = (slot && bus.wr_ready) ||
                  (mode < 2 && !slot && !bus.wr_ready) ||
                  (mode == 2 && clr_next > 0 && clr_next < FB_N && bus.wr_ready);
        if (mode != 2) clr_next <= 0;
        if (mon_on) begin
            if (slot) begin
                if (!(bus.mem_en && !bus.mem_we && bus.mem_addr == ADDR_W'(ea)))
                    scan_err <= scan_err + 1;
                snap_val[h2/4] <= ram[ea];
                snap_row[h2/4] <= v2;
                snap_ep[h2/4]  <= epoch;
            end else if (bus.mem_en && !bus.mem_we) begin
                spur_err <= spur_err + 1;
            end
            if (rdy_bad) ready_err <= ready_err + 1;
            if (bus.hc_in < 640 && bus.vc_in < 480) begin
                col = int'(bus.hc_in) / 4;
                if (snap_ep[col] == epoch && snap_row[col] == int'(bus.vc_in)) begin
                    pix_cnt <= pix_cnt + 1;
                    if ({bus.pix_red, bus.pix_green, bus.pix_blue} != snap_val[col])
                        pix_err <= pix_err + 1;
                end
            end
            case (mode)
                0: if (wr) unexp_wr <= unexp_wr + 1;
                1: begin
                    if (wr != hs) hs_err <= hs_err + 1;
                    if (hs) hs_cnt <= hs_cnt + 1;
                    if (wr) wr_cnt <= wr_cnt + 1;
                    if (wr && (bus.mem_addr != bus.wr_addr || bus.mem_wdata != bus.wr_data))
                        wr_bad <= wr_bad + 1;
                end
                default: begin
                    if (hs && !wr) hs_err <= hs_err + 1;
                    if (wr && hs) begin
                        if (bus.mem_addr != bus.wr_addr || bus.mem_wdata != bus.wr_data)
                            wr_bad <= wr_bad + 1;
                    end else if (wr) begin
                        if (clr_next == 0) begin
                            first_clr_vc <= int'(bus.vc_in);
                            first_clr_hc <= int'(bus.hc_in);
                        end
                        if (bus.mem_addr != ADDR_W'(clr_next) || bus.mem_wdata != exp_col)
                            clr_err <= clr_err + 1;
                        clr_next <= clr_next + 1;
                    end
                end
            endcase
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step_vga();
        @(posedge clk);
        #1;
        if (bus.hc_in == 10'd799) begin
            bus.hc_in = '0;
            bus.vc_in = (bus.vc_in == 10'd524) ? 10'd0 : bus.vc_in + 10'd1;
        end else begin
            bus.hc_in = bus.hc_in + 10'd1;
        end
    endtask

    task automatic jump(input int h, input int v);
        @(posedge clk);
        #1;
        bus.hc_in = 10'(h);
        bus.vc_in = 10'(v);
        epoch++;
    endtask

    // ends on the negedge of the cycle where hc==h, vc==v
    task automatic goto_pos(input int h, input int v);
        int n = 0;
        while (!(bus.hc_in == 10'(h) && bus.vc_in == 10'(v)) && n < 10000) begin
            step_vga();
            n++;
        end
        check("reach_pos", (bus.hc_in == 10'(h) && bus.vc_in == 10'(v)), 1);
        @(negedge clk);
    endtask

    task automatic pulse_clear(input logic [11:0] c);
        bus.clear_col = c;
        bus.clear_req = 1'b1;
        step_vga();
        bus.clear_req = 1'b0;
    endtask

    task automatic wait_clr(input int target, input int budget);
        int n = 0;
        while (clr_next < target && n < budget) begin
            step_vga();
            n++;
        end
        check("clr_progress", (clr_next >= target), 1);
    endtask

    function automatic logic [11:0] pix();
        return {bus.pix_red, bus.pix_green, bus.pix_blue};
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int n, bad;
        bus.hc_in     = 10'd790;
        bus.vc_in     = 10'd524;
        bus.wr_valid  = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.clear_req = 1'b0;
        bus.clear_col = '0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_pix",   pix(), 12'h000);
        check("rst_busy",  bus.clear_busy, 0);
        check("rst_ready", bus.wr_ready, 0);
        check("rst_mem_en", bus.mem_en, 0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        ram_load = 1'b0;
        mon_on   = 1'b1;

        // scanout: first pixels, frame_start, line wrap
        goto_pos(0, 0);
        check("pix_0_0", pix(), 12'h000);
        check("frame_start_hi", bus.frame_start, 1);
        goto_pos(1, 0);
        check("frame_start_lo", bus.frame_start, 0);
        goto_pos(3, 0);
        check("pix_3_0", pix(), 12'h000);
        goto_pos(4, 0);
        check("pix_4_0", pix(), 12'h001);
        goto_pos(798, 3);
        check("wrap_rd_en", {bus.mem_en, bus.mem_we}, 2'b10);
        check("wrap_rd_addr", bus.mem_addr, 160);
        goto_pos(4, 4);
        check("pix_4_4", pix(), 12'd161);

        // writer held valid over hc=100..139 on line 4: 10 slots, 30 writes
        goto_pos(99, 4);
        step_vga();
        mode         = 1;
        bus.wr_addr  = 15'd5;
        bus.wr_data  = 12'hABC;
        bus.wr_valid = 1'b1;
        repeat (39) step_vga();
        step_vga();
        bus.wr_valid = 1'b0;
        step_vga();
        mode = 0;
        check("wr_handshakes", hs_cnt, 30);
        check("wr_writes", wr_cnt, 30);
        check("wr_hs_match", hs_err, 0);
        check("wr_addr_data", wr_bad, 0);
        check("ram5", ram[5], 12'hABC);
        jump(0, 0);
        goto_pos(19, 0);
        check("pix_col4", pix(), 12'h004);
        goto_pos(21, 0);
        check("pix_readback", pix(), 12'hABC);

        // no read at end of last visible line; frame wrap reads address 0
        jump(790, 479);
        goto_pos(798, 479);
        check("no_rd_vc479", bus.mem_en, 0);
        jump(790, 524);
        goto_pos(798, 524);
        check("wrap_frame_en", {bus.mem_en, bus.mem_we}, 2'b10);
        check("wrap_frame_addr", bus.mem_addr, 0);

        // clear requested mid-frame, waits for vblank, spills into video
        jump(0, 100);
        mode    = 2;
        exp_col = 12'h0F0;
        pulse_clear(12'h0F0);
        @(negedge clk);
        check("clr_busy_set", bus.clear_busy, 1);
        repeat (800) step_vga();
        pulse_clear(12'hF00);
        @(negedge clk);
        check("clr_busy_still", bus.clear_busy, 1);
        jump(0, 479);
        wait_clr(1, 2000);
        check("clr_first_vc", first_clr_vc, 480);
        check("clr_first_hc", first_clr_hc, 1);
        bus.wr_addr  = 15'd7;
        bus.wr_data  = 12'h123;
        bus.wr_valid = 1'b1;
        repeat (100) step_vga();
        jump(0, 523);
        n = 0;
        while (bus.clear_busy && n < 40000) begin
            step_vga();
            n++;
        end
        check("clr_done", bus.clear_busy, 0);
        repeat (8) step_vga();
        bus.wr_valid = 1'b0;
        step_vga();
        check("clr_count", clr_next, FB_N);
        check("clr_addr_data", clr_err, 0);
        check("clr_writer", wr_bad, 0);
        check("clr_hs", hs_err, 0);
        check("scan_reads", scan_err, 0);
        check("spurious_reads", spur_err, 0);
        check("ready_rule", ready_err, 0);
        check("pix_errors", pix_err, 0);
        check("pix_checked", (pix_cnt > 100), 1);
        check("unexpected_wr", unexp_wr, 0);
        bad = 0;
        for (int a = 0; a < FB_N; a++) begin
            if (a != 7 && ram[a] != 12'h0F0) bad++;
        end
        check("clr_ram_all", bad, 0);
        check("clr_ram7_writer", ram[7], 12'h123);
        check("clr_ram_beyond", ram[FB_N], 12'hB00);

        // reset while clearing
        mode = 0;
        jump(0, 480);
        step_vga();
        mode    = 2;
        exp_col = 12'h00F;
        pulse_clear(12'h00F);
        wait_clr(5000, 10000);
        mon_on = 1'b0;
        rst    = 1'b1;
        #1;
        check("mrst_pix",   pix(), 12'h000);
        check("mrst_busy",  bus.clear_busy, 0);
        check("mrst_mem",   {bus.mem_en, bus.mem_we}, 2'b00);
        check("mrst_addr",  bus.mem_addr, 0);
        check("mrst_wdata", bus.mem_wdata, 0);
        check("mrst_ready", bus.wr_ready, 0);
        check("mrst_fs",    bus.frame_start, 0);
        mode = 0;
        repeat (2) step_vga();
        check("mrst_ram4999", ram[4999], 12'h00F);
        check("mrst_ram5000", ram[5000], 12'h0F0);
        rst = 1'b0;
        epoch++;
        mon_on = 1'b1;
        step_vga();
        check("post_rst_busy", bus.clear_busy, 0);
        mode    = 2;
        exp_col = 12'hFFF;
        pulse_clear(12'hFFF);
        wait_clr(20, 200);
        check("restart_busy", bus.clear_busy, 1);
        check("restart_addr_data", clr_err, 0);
        check("restart_ram0", ram[0], 12'hFFF);
        check("restart_ram19", ram[19], 12'hFFF);
        check("restart_ram25", ram[25], 12'h00F);
        check("final_scan", scan_err, 0);
        check("final_ready", ready_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
